// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter in front of a single APB master port: grants one of NREQ
// requesters, runs SETUP/ACCESS with wait states and an ACCESS timeout.
module apb_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     p_clk,
  input  logic                     p_reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_done,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_slverr,
  output logic [ADDR_W-1:0]        p_add,
  output logic                     p_sel,
  output logic                     p_enable,
  output logic                     p_write,
  output logic [DATA_W-1:0]        p_wdata,
  input  logic [DATA_W-1:0]        p_rdata,
  input  logic                     p_ready,
  input  logic                     p_slverr,
  output logic [1:0]               ns
);

  localparam int PW      = $clog2(NREQ);
  localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETUP  = 2'b01,
    S_ACCESS = 2'b10
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] grant;
  logic [PW-1:0] pick;
  logic [PW:0]   idx;
  logic          found;
  logic          any_req;
  logic          timeout_hit;
  logic          finish;
  logic [CW-1:0] cnt;

  // Handshake: a requester holds req_valid and its fields stable until the
  // clock edge at which its req_done bit is sampled high; req_done is a
  // single-cycle pulse driven combinationally in the completing ACCESS cycle.

  assign any_req     = |req_valid;
  assign timeout_hit = (TIMEOUT > 0) && (cnt == CW'(TO_LAST)) && !p_ready;
  assign finish      = (state == S_ACCESS) && (p_ready || timeout_hit);

  // Search upward from the slot after the last winner, wrapping at NREQ.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (PW+1)'(ptr) + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req_valid[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:   next_state = any_req ? S_SETUP : S_IDLE;
      S_SETUP:  next_state = S_ACCESS;
      S_ACCESS: next_state = finish ? S_IDLE : S_ACCESS;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      ptr     <= PW'(NREQ - 1);
      grant   <= '0;
      p_add   <= '0;
      p_wdata <= '0;
      p_write <= 1'b0;
      cnt     <= '0;
    end else begin
      if (state == S_IDLE && any_req) begin
        grant   <= pick;
        ptr     <= pick;
        p_add   <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
        p_wdata <= req_wdata[int'(pick)*DATA_W +: DATA_W];
        p_write <= req_write[pick];
      end
      if (state == S_ACCESS && !finish) cnt <= cnt + 1'b1;
      else                              cnt <= '0;
    end
  end

  always_comb begin
    ns         = state;
    p_sel      = (state == S_SETUP) || (state == S_ACCESS);
    p_enable   = (state == S_ACCESS);
    req_done   = '0;
    rsp_rdata  = '0;
    rsp_slverr = 1'b0;
    if (finish) begin
      req_done[grant] = 1'b1;
      rsp_slverr      = p_ready ? p_slverr : 1'b1;
      rsp_rdata       = (p_ready && !p_write) ? p_rdata : '0;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of arbitration, APB phases and completion.
module tb_apb_master_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 16;

  logic              p_clk = 1'b0;
  logic              p_reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_write = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]   req_done;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_slverr;
  logic [AW-1:0]     p_add;
  logic              p_sel;
  logic              p_enable;
  logic              p_write;
  logic [DW-1:0]     p_wdata;
  logic [DW-1:0]     p_rdata = '0;
  logic              p_ready = 1'b0;
  logic              p_slverr = 1'b0;
  logic [1:0]        ns;

  apb_master_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .p_clk(p_clk), .p_reset(p_reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .p_add(p_add), .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write),
    .p_wdata(p_wdata), .p_rdata(p_rdata), .p_ready(p_ready),
    .p_slverr(p_slverr), .ns(ns)
  );

  // clock / reset
  always #5 p_clk = ~p_clk;

  int n_vec = 0;
  int n_bad = 0;

  // transaction model: phase 0 idle, 1 setup, 2 access
  int m_ph = 0;
  int m_ptr = NREQ - 1;
  int m_g = 0;
  int m_wait = 0;
  int m_acnt = 0;
  int done_cnt = 0;
  logic [NREQ-1:0] fin = '0;
  bit  rand_req = 1'b0;
  bit  hold_req = 1'b0;
  int  force_wait = -1;
  int  force_err = -1;
  logic [7:0] exp_q[$];
  int  grant_log[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(int ptr, logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // driver tasks
  task automatic post(int i, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    req_valid[i]           = 1'b1;
    req_write[i]           = w;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  // One clock cycle: called at a falling edge, returns at the next one.
  task automatic cycle();
    logic [NREQ-1:0] exp_done;
    logic [DW-1:0]   exp_rd;
    logic            exp_err;
    bit              fin_now;
    int              gi;
    for (int i = 0; i < NREQ; i++) begin
      if (fin[i]) begin
        fin[i] = 1'b0;
        if (hold_req) post(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
        else          req_valid[i] = 1'b0;
      end else if (rand_req && !req_valid[i] && $urandom_range(0, 2) == 0) begin
        post(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
    end
    p_ready  = 1'b0;
    p_slverr = 1'($urandom_range(0, 1));
    p_rdata  = $urandom;
    exp_done = '0;
    exp_rd   = '0;
    exp_err  = 1'b0;
    fin_now  = 1'b0;
    if (m_ph == 2) begin
      p_ready = (m_acnt == m_wait);
      if (p_ready && force_err >= 0) p_slverr = 1'(force_err);
      fin_now = (m_acnt == m_wait) || (m_acnt == TO - 1);
      if (fin_now) begin
        exp_done[m_g] = 1'b1;
        exp_err = p_ready ? p_slverr : 1'b1;
        exp_rd  = (p_ready && !req_write[m_g]) ? p_rdata : '0;
      end
    end
    #1;
    chk("ns", ns, (m_ph == 0) ? 2'b00 : (m_ph == 1) ? 2'b01 : 2'b10);
    chk("p_sel", p_sel, m_ph != 0);
    chk("p_enable", p_enable, m_ph == 2);
    chk("req_done", req_done, exp_done);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_slverr", rsp_slverr, exp_err);
    if (m_ph != 0) begin
      chk("p_add", p_add, req_addr[m_g*AW +: AW]);
      chk("p_wdata", p_wdata, req_wdata[m_g*DW +: DW]);
      chk("p_write", p_write, req_write[m_g]);
    end
    case (m_ph)
      0: if (req_valid != '0) begin
           m_g = pick(m_ptr, req_valid);
           m_ptr = m_g;
           exp_q.push_back(8'(m_g));
           m_ph = 1;
         end
      1: begin
           if (force_wait >= 0) m_wait = force_wait;
           else m_wait = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 3);
           m_acnt = 0;
           m_ph = 2;
         end
      default:
        if (fin_now) begin
          gi = 255;
          for (int i = 0; i < NREQ; i++) if (req_done[i]) gi = i;
          chk("sb_grant", 64'(gi), 64'(exp_q.pop_front()));
          grant_log.push_back(m_g);
          fin[m_g] = 1'b1;
          done_cnt++;
          m_ph = 0;
        end else begin
          m_acnt++;
        end
    endcase
    @(negedge p_clk);
  endtask

  task automatic run_done(int n, int budget);
    int tgt = done_cnt + n;
    int c = 0;
    while (done_cnt < tgt && c < budget) begin
      cycle();
      c++;
    end
    chk("done_budget", done_cnt >= tgt, 1'b1);
  endtask

  task automatic drain();
    int c = 0;
    while ((m_ph != 0 || req_valid != '0 || fin != '0) && c < 400) begin
      cycle();
      c++;
    end
    chk("drain_budget", c < 400, 1'b1);
  endtask

  initial begin
    int c;
    p_reset = 1'b1;
    repeat (2) @(negedge p_clk);
    #1;
    chk("rst_ns", ns, 2'b00);
    chk("rst_p_sel", p_sel, 1'b0);
    chk("rst_p_enable", p_enable, 1'b0);
    chk("rst_p_add", p_add, 32'h0);
    chk("rst_p_wdata", p_wdata, 32'h0);
    chk("rst_p_write", p_write, 1'b0);
    chk("rst_req_done", req_done, 2'b00);
    p_reset = 1'b0;
    @(negedge p_clk);

    // write, no wait states
    force_wait = 0; force_err = 0;
    post(0, 1'b1, 32'h4, 32'h7);
    run_done(1, 20); drain();
    // read by requester 1
    post(1, 1'b0, 32'h4, 32'h0);
    run_done(1, 20); drain();

    // contention, both held continuously valid
    force_wait = -1; force_err = -1;
    hold_req = 1'b1;
    grant_log.delete();
    post(0, 1'b1, $urandom, $urandom);
    post(1, 1'b0, $urandom, $urandom);
    run_done(4, 60);
    hold_req = 1'b0;
    for (int k = 0; k < 4; k++) chk("rr_order", 64'(grant_log[k]), 64'(k % 2));
    drain();

    // wait states with slave error on the final cycle
    force_wait = 3; force_err = 1;
    post(0, 1'b1, 32'h1234_5678, 32'hcafe_f00d);
    run_done(1, 20); drain();

    // ACCESS timeout with p_ready stuck low
    force_wait = 100; force_err = -1;
    post(1, 1'b0, 32'h80, 32'h0);
    run_done(1, 40); drain();

    // asynchronous reset in the middle of ACCESS
    post(0, 1'b1, 32'h40, 32'h55);
    c = 0;
    while (!(m_ph == 2 && m_acnt >= 2) && c < 20) begin
      cycle();
      c++;
    end
    chk("reach_access", m_ph == 2, 1'b1);
    #2 p_reset = 1'b1;
    #1;
    chk("arst_ns", ns, 2'b00);
    chk("arst_p_sel", p_sel, 1'b0);
    chk("arst_p_enable", p_enable, 1'b0);
    chk("arst_req_done", req_done, 2'b00);
    @(negedge p_clk);
    p_reset = 1'b0;
    req_valid = '0; fin = '0; exp_q.delete();
    m_ph = 0; m_ptr = NREQ - 1; force_wait = -1;
    grant_log.delete();
    post(0, 1'b0, $urandom, $urandom);
    post(1, 1'b1, $urandom, $urandom);
    run_done(1, 40);
    chk("post_reset_winner", 64'(grant_log[0]), 64'd0);
    drain();

    // random traffic
    rand_req = 1'b1;
    run_done(60, 4000);
    rand_req = 1'b0;
    drain();

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Round-robin arbiter and APB master sequencer that shares one APB slave port (p_add/p_sel/p_enable/p_write/p_wdata, p_rdata/p_ready/p_slverr) between NREQ requesters.
- Each requester posts a single read or write command. The block grants one requester, runs the APB SETUP then ACCESS phases, and returns the result.
- It sits between the bus-side clients and the existing apb slave. It adds wait-state handling and an ACCESS timeout.

Parameters:
NREQ, 2, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 16, maximum ACCESS cycles with p_ready low before abort (0 = no timeout)

Ports:
p_clk  in  1  clock, rising edge; the only clock.
p_reset  in  1  asynchronous, active-high reset.
req_valid  in  NREQ  per-requester command pending; held until req_done.
req_write  in  NREQ  per-requester direction: 1 = write, 0 = read.
req_addr  in  NREQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
req_wdata  in  NREQ*DATA_W  packed write data, sliced the same way.
req_done  out  NREQ  one-hot completion pulse to the granted requester.
rsp_rdata  out  DATA_W  read data, valid while req_done is high.
rsp_slverr  out  1  error status, valid while req_done is high.
p_add  out  ADDR_W  APB address.
p_sel  out  1  APB select.
p_enable  out  1  APB enable.
p_write  out  1  APB direction.
p_wdata  out  DATA_W  APB write data.
p_rdata  in  DATA_W  APB read data.
p_ready  in  1  APB ready.
p_slverr  in  1  APB slave error.
ns  out  2  current state: 00 IDLE, 01 SETUP, 10 ACCESS.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - state = IDLE; p_add, p_wdata, p_sel, p_enable, p_write = 0.
  - Round-robin pointer = NREQ-1, so requester 0 wins the first arbitration.
  - Timeout counter = 0; any in-flight transfer is dropped with no req_done.
- IDLE:
  - If any req_valid is high at a clock edge, grant the first requester searching upward from (pointer+1) mod NREQ, with wrap-around.
  - Latch its addr, wdata and write into p_add, p_wdata and p_write, and update the pointer to the granted index.
  - Next state SETUP. With no requests, stay in IDLE and hold p_add/p_wdata/p_write.
- SETUP: exactly one cycle with p_sel=1, p_enable=0; unconditional move to ACCESS.
- ACCESS: p_sel=1, p_enable=1; address, data and direction stay stable.
  - p_ready=1 completes the transfer:
    - req_done[grant] = 1 combinationally in this same cycle.
    - rsp_rdata = p_rdata for a read, 0 for a write.
    - rsp_slverr = p_slverr.
    - Next state IDLE: p_sel and p_enable go to 0 at the following edge.
  - p_ready=0: stay in ACCESS and increment the timeout counter.
  - If TIMEOUT>0 and the counter has reached TIMEOUT-1 with p_ready still low, abort:
    - req_done[grant] = 1, rsp_slverr = 1, rsp_rdata = 0.
    - Next state IDLE.
  - The counter clears on leaving ACCESS.
- Outputs outside completion: req_done = 0, rsp_rdata = 0, rsp_slverr = 0.
- Requester contract:
  - Keep req_valid and the fields stable from assertion until the edge where req_done is sampled high.
  - Deasserting req_valid after it is granted has no effect; the transfer still completes.
- Latency: req_valid seen at edge N gives SETUP in cycle N+1 and ACCESS in N+2. Earliest req_done is in cycle N+2, sampled at edge N+3. Every transfer passes through IDLE, so back-to-back transfers take a minimum of 3 cycles.
- Fairness: a requester that has just completed is lowest priority at the next arbitration. With all NREQ requesters continuously valid, grants rotate 0, 1, ..., NREQ-1, 0, ...
- A requester whose req_valid rises during a transfer waits for the next IDLE arbitration.
- ns always reflects the registered state. Encoding 11 is unreachable; if entered, next state is IDLE.

Test Plan:
1. Write, no wait states: reset, then req_valid[0]=1, req_write[0]=1, addr 0x4, wdata 0x7 → ns 00→01→10. p_add=0x4, p_wdata=0x7, p_write=1 during SETUP/ACCESS. req_done=01 for one cycle, rsp_slverr=0, rsp_rdata=0.
2. Read by requester 1: addr 0x4, slave returns p_rdata 0x7, p_ready=1 → req_done=10 in the ACCESS cycle, rsp_rdata=0x7, p_write=0.
3. Contention: both req_valid high and held for 4 transfers → grant order 0,1,0,1, each via SETUP/ACCESS/IDLE. req_done pulses alternate 01,10,01,10.
4. Wait states: p_ready held low for 3 ACCESS cycles then high → ACCESS lasts 4 cycles with p_add/p_wdata stable; single req_done; p_slverr=1 on the final cycle gives rsp_slverr=1.
5. Timeout: TIMEOUT=16, p_ready stuck low → req_done pulses in the 16th ACCESS cycle with rsp_slverr=1, rsp_rdata=0; ns returns to 00; p_sel=0 afterwards.
6. Reset mid-ACCESS: assert p_reset asynchronously while ns=10 → ns=00 and p_sel=p_enable=0 immediately, no req_done. After release, requester 0 wins the first arbitration.
